// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stage indices, FSM encoding and constants shared by the stall/flush sequencer.
package pipe_ctrl_pkg;
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;
   localparam int NSTG    = 5;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
   localparam logic [NSTG-1:0] FLUSH_EXC  = 5'b01111;
   localparam logic [NSTG-1:0] FLUSH_PEND = 5'b00011;
   typedef enum logic {RUN = 1'b0, REDIR_PEND = 1'b1} state_e;
endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// stall_prio_enc: highest requesting stage k stalls stages 0..k and bubbles stage k+1.
module stall_prio_enc
   import pipe_ctrl_pkg::*;
(
   input  logic [STG_MEM:0]  req_i,
   output logic [NSTG-1:0]   stall_o,
   output logic [NSTG-1:0]   flush_o
);
   always_comb begin
      stall_o = '0;
      flush_o = '0;
      for (int i = 0; i < STG_WB; i++) begin
         stall_o[i]   = |(req_i >> i);
         flush_o[i+1] = req_i[i] && ((req_i >> (i + 1)) == '0);
      end
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer with exception redirect and stall watchdog.
// Define PIPE_CTRL_PERF_EN to add stall-cycle and redirect performance counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0]       EXC_VECTOR = EXC_VECTOR_DEF,
   parameter int                WDOG_W     = 16,
   parameter logic [WDOG_W-1:0] WDOG_LIMIT = {WDOG_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_stallreq,
   input  logic              id_stallreq,
   input  logic              ex_stallreq,
   input  logic              mem_stallreq,
   input  logic              exc_valid,
   input  logic              exc_eret,
   input  logic [31:0]       cp0_epc,
   output logic [NSTG-1:0]   stall_o,
   output logic [NSTG-1:0]   flush_o,
   output logic              redirect_en_o,
   output logic [31:0]       redirect_pc_o,
   output logic              busy_o,
   output logic              wdog_err_o
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt_o,
   output logic [31:0]       perf_flush_cnt_o
`endif
);
   state_e            state_q, state_d;
   logic [31:0]       pend_pc_q, pend_pc_d, target;
   logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic              wdog_err_q, wdog_err_d;
   logic [STG_MEM:0]  req;
   logic [NSTG-1:0]   enc_stall, enc_flush;
   logic              pend, exc, redir;

   stall_prio_enc u_enc (
      .req_i   (req),
      .stall_o (enc_stall),
      .flush_o (enc_flush)
   );

   always_comb begin
      req           = {mem_stallreq, ex_stallreq, id_stallreq, if_stallreq};
      pend          = state_q == REDIR_PEND;
      exc           = !pend && exc_valid;
      target        = exc_eret ? cp0_epc : EXC_VECTOR;
      redir         = !rst && (pend || exc) && !if_stallreq;
      stall_o       = (rst || pend || exc) ? '0 : enc_stall;
      flush_o       = rst ? '0 : pend ? FLUSH_PEND : exc ? FLUSH_EXC : enc_flush;
      redirect_en_o = redir;
      redirect_pc_o = !redir ? '0 : pend ? pend_pc_q : target;
      busy_o        = pend && !rst;
      wdog_err_o    = wdog_err_q;
      state_d       = ((pend || exc) && if_stallreq) ? REDIR_PEND : RUN;
      pend_pc_d     = (exc && if_stallreq) ? target : pend_pc_q;
      // saturating count of back-to-back stalled cycles
      wdog_cnt_d    = (|stall_o && !redir) ? wdog_cnt_q + WDOG_W'(!(&wdog_cnt_q)) : '0;
      wdog_err_d    = wdog_err_q || (wdog_cnt_d == WDOG_LIMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         pend_pc_q  <= '0;
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_pc_q  <= pend_pc_d;
         wdog_cnt_q <= wdog_cnt_d;
         wdog_err_q <= wdog_err_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt_o <= '0;
         perf_flush_cnt_o <= '0;
      end else begin
         perf_stall_cnt_o <= perf_stall_cnt_o + 32'(|stall_o);
         perf_flush_cnt_o <= perf_flush_cnt_o + 32'(redir);
      end
   end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (watchdog limit shortened to 4).
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_r = 1'b0, id_r = 1'b0, ex_r = 1'b0, mem_r = 1'b0;
   logic        exc_valid = 1'b0, exc_eret = 1'b0;
   logic [31:0] cp0_epc = '0;
   logic [4:0]  stall_o, flush_o;
   logic        redirect_en_o, busy_o, wdog_err_o;
   logic [31:0] redirect_pc_o;
   int          checks = 0;
   int          errors = 0;

   pipe_ctrl #(.WDOG_LIMIT(16'd4)) dut (
      .clk           (clk),
      .rst           (rst),
      .if_stallreq   (if_r),
      .id_stallreq   (id_r),
      .ex_stallreq   (ex_r),
      .mem_stallreq  (mem_r),
      .exc_valid     (exc_valid),
      .exc_eret      (exc_eret),
      .cp0_epc       (cp0_epc),
      .stall_o       (stall_o),
      .flush_o       (flush_o),
      .redirect_en_o (redirect_en_o),
      .redirect_pc_o (redirect_pc_o),
      .busy_o        (busy_o),
      .wdog_err_o    (wdog_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic f, input logic d, input logic e, input logic m,
                        input logic ev, input logic er, input logic [31:0] epc);
      @(negedge clk);
      if_r = f; id_r = d; ex_r = e; mem_r = m;
      exc_valid = ev; exc_eret = er; cp0_epc = epc;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [4:0] st, input logic [4:0] fl,
                             input logic ren, input logic [31:0] pc, input logic bsy,
                             input logic werr);
      chk({tag, ".stall"}, 32'(stall_o), 32'(st));
      chk({tag, ".flush"}, 32'(flush_o), 32'(fl));
      chk({tag, ".ren"}, 32'(redirect_en_o), 32'(ren));
      chk({tag, ".pc"}, redirect_pc_o, pc);
      chk({tag, ".busy"}, 32'(busy_o), 32'(bsy));
      chk({tag, ".wdog"}, 32'(wdog_err_o), 32'(werr));
   endtask

   initial begin
      drive(0, 1, 0, 0, 1, 0, 32'h0);
      expect_out("reset", 5'b0, 5'b0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      expect_out("idle", 5'b00000, 5'b00000, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      expect_out("mem", 5'b01111, 5'b10000, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0);
      expect_out("ex", 5'b00111, 5'b01000, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      expect_out("id", 5'b00011, 5'b00100, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      expect_out("if", 5'b00001, 5'b00010, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 1, 0, 0, 0);
      expect_out("id_mem", 5'b01111, 5'b10000, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 1, 0, 32'h1111_2222);
      expect_out("exc_free", 5'b0, 5'b01111, 1, 32'hBFC00380, 0, 0);
      drive(0, 0, 0, 0, 1, 1, 32'h8000_4000);
      expect_out("eret_free", 5'b0, 5'b01111, 1, 32'h8000_4000, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("after_exc", 5'b0, 5'b0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 1, 32'h8000_1234);
      expect_out("eret_busy", 5'b0, 5'b01111, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
      expect_out("pend1", 5'b0, 5'b00011, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      expect_out("pend2", 5'b0, 5'b00011, 0, 0, 1, 0);
      drive(1, 0, 0, 1, 0, 0, 0);
      expect_out("pend3", 5'b0, 5'b00011, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0, 0);
      expect_out("pend_go", 5'b0, 5'b00011, 1, 32'h8000_1234, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("post_redir", 5'b0, 5'b0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      expect_out("rst_pend", 5'b0, 5'b00011, 0, 0, 1, 0);
      if_r = 1'b0;
      rst = 1'b1;
      #1;
      expect_out("rst_mid", 5'b0, 5'b0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      expect_out("rst_after", 5'b0, 5'b0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("rst_after2", 5'b0, 5'b0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0);
      expect_out("wd3_last", 5'b00011, 5'b00100, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("wd3_gap", 5'b0, 5'b0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0);
      expect_out("wd4_last", 5'b00011, 5'b00100, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("wd4_set", 5'b0, 5'b0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      expect_out("wd4_sticky", 5'b0, 5'b0, 0, 0, 0, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("wd_rst_clear", 32'(wdog_err_o), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core: IF=0, ID=1, EX=2, MEM=3, WB=4.
- Collects stall requests from the stages and drives each stage's stall and flush inputs. The decoder's stall/flush inputs come from here, and the decoder's stall request goes into it.
- Turns MEM-stage exceptions and ERET into a front-end PC redirect. The redirect is held until IF can accept it.
- Runs a stall watchdog that flags a pipeline stuck in stall.

Parameters:
- EXC_VECTOR, 32'hBFC00380: general exception entry PC.
- WDOG_W, 16: watchdog counter width.
- WDOG_LIMIT, 16'hFFFF: consecutive stall cycles before wdog_err is set.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_stallreq  in  1  IF busy (icache miss); IF cannot accept a new PC.
- id_stallreq  in  1  load-use hazard.
- ex_stallreq  in  1  multi-cycle mul/div busy.
- mem_stallreq  in  1  dcache/bus busy.
- exc_valid  in  1  exception committed in MEM.
- exc_eret  in  1  qualifier: the MEM instruction is ERET.
- cp0_epc  in  32  return PC used for ERET.
- stall_o  out  5  per-stage hold (bit i = stage i).
- flush_o  out  5  per-stage bubble/clear.
- redirect_en_o  out  1  load redirect_pc_o into the PC.
- redirect_pc_o  out  32  redirect target.
- busy_o  out  1  a redirect is pending.
- wdog_err_o  out  1  sticky watchdog error.

Behaviour:
- Reset: state=RUN, pend_pc=0, wdog_cnt=0, wdog_err=0. While rst=1, all outputs are 0.
- Stall priority is MEM > EX > ID > IF. k = highest stage with a request.
  - stall_o[0..k]=1.
  - flush_o[k+1]=1 (bubble into the next stage), only when k<4.
  - Every other bit is 0.
  - Example: id_stallreq alone gives stall_o=5'b00011, flush_o=5'b00100.
- Outputs stall_o and flush_o are combinational from the state and the inputs (zero latency).
- FSM has two states: RUN and REDIR_PEND.
- RUN, exc_valid=1:
  - Exception overrides all stall requests. flush_o=5'b01111, stall_o=0.
  - Target is cp0_epc when exc_eret=1, otherwise EXC_VECTOR.
  - If if_stallreq=0: redirect_en_o=1 and redirect_pc_o=target in the same cycle; stay in RUN.
  - If if_stallreq=1: redirect_en_o=0; latch pend_pc=target; go to REDIR_PEND.
- REDIR_PEND:
  - flush_o=5'b00011 every cycle (kills wrong-path IF/ID); stall_o=0; busy_o=1.
  - The first cycle with if_stallreq=0: redirect_en_o=1, redirect_pc_o=pend_pc; go to RUN.
  - exc_valid in this state is ignored (MEM is already flushed and cannot raise a new exception).
- redirect_pc_o=0 whenever redirect_en_o=0.
- Watchdog:
  - wdog_cnt increments (saturating) on every cycle with any stall_o bit set and no redirect. Any other cycle clears it.
  - When wdog_cnt reaches WDOG_LIMIT, wdog_err is set. It is cleared only by rst.
- Reset asserted mid-REDIR_PEND drops the pending redirect; no redirect_en pulse is issued.
- exc_eret is don't-care when exc_valid=0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt_o[31:0] (cycles with any stall_o bit set) and perf_flush_cnt_o[31:0] (number of redirect_en_o pulses).
  - Both are 32-bit wrap-around counters, reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file:
  - stage index constants STG_IF..STG_WB.
  - stage count 5.
  - FSM encoding (RUN=1'b0, REDIR_PEND=1'b1).
  - default EXC_VECTOR.
- Sub-module stall_prio_enc: combinational priority encoder from the request vector to stall/flush vectors. Reused by the exception-override mux.

Test Plan:
- Single requests:
  - mem_stallreq=1 only -> stall_o=5'b01111, flush_o=5'b10000.
  - ex_stallreq only -> stall_o=5'b00111, flush_o=5'b01000.
- Simultaneous requests: id_stallreq=1 and mem_stallreq=1 -> MEM wins: stall_o=5'b01111, flush_o=5'b10000.
- Exception while IF is free: exc_valid=1, exc_eret=0, if_stallreq=0, ex_stallreq=1 -> same cycle: flush_o=5'b01111, stall_o=0, redirect_en_o=1, redirect_pc_o=32'hBFC00380.
- ERET with IF busy:
  - exc_valid=1, exc_eret=1, cp0_epc=32'h8000_1234, if_stallreq=1 for 3 cycles.
  - Expect busy_o=1 and flush_o=5'b00011 for 3 cycles, then a single redirect_en_o pulse with PC 32'h8000_1234 when if_stallreq drops.
- Reset in REDIR_PEND: assert rst mid-pending -> outputs 0 immediately; after release, no redirect pulse.
- Watchdog with WDOG_LIMIT=4:
  - Hold id_stallreq 4 cycles -> wdog_err_o=1, and it stays 1 after the stall clears.
  - A 3-cycle stall followed by a gap -> wdog_err_o stays 0.
